sync_ram_dual_multi_w: RTL and testbench
========================================

SYNC_RAM_DUAL_MULTI_W -- requirements
Module: sync_ram_dual_multi_w

Interface
REQ-001 SHALL have parameter num_in, default 4, number of independent write ports.
REQ-002 SHALL have parameter d_width, default 8, data word width.
REQ-003 SHALL have parameter a_width, default 4, address width; depth 2**a_width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid  input  [num_in-1:0]  per-port write request.
REQ-007 SHALL have port wr_ready  output  [num_in-1:0]  per-port slot free.
REQ-008 SHALL have port wr_addr  input  array[num_in] of a_width  per-port write address.
REQ-009 SHALL have port wr_data  input  array[num_in] of d_width  per-port write data.
REQ-010 SHALL have port address_r  input  a_width  read address.
REQ-011 SHALL have port data_out  output  d_width  registered read data.
REQ-012 SHALL have port idle  output  1  high when no write is pending.

Function
REQ-013 SHALL hold one posted-write slot per port (pend flag, address, data).
REQ-014 SHALL drive wr_ready[i] = !pend[i], from registered state only, no combinational path from wr_valid.
REQ-015 SHALL accept port i on an edge with wr_valid[i] && wr_ready[i]: load slot, set pend[i].
REQ-016 SHALL commit at most one pending slot to memory per cycle.
REQ-017 SHALL select the slot round-robin: first pend[i] searching from rr_ptr upward, modulo num_in.
REQ-018 SHALL, on commit of slot i, write mem[addr_i] <= data_i, clear pend[i], and set rr_ptr <= (i+1) mod num_in.
REQ-019 SHALL leave rr_ptr unchanged in cycles with no pending slot.
REQ-020 SHALL accept on edge N, commit no earlier than edge N+1, and refill port i no earlier than edge N+2 (max 1 write per 2 cycles per port).
REQ-021 SHALL register data_out <= mem[address_r] every edge, 1-cycle read latency.
REQ-022 SHALL resolve same-address writes by commit order; later commit wins.
REQ-023 SHALL ignore wr_addr/wr_data while wr_valid[i] is low or pend[i] is high.
REQ-024 SHALL drive idle = (pend == 0), registered-state derived.
REQ-025 SHALL bound worst-case wait of a pending slot to num_in-1 commit cycles.

Reset
REQ-026 SHALL on reset_n low clear all pend, set rr_ptr=0, and set data_out=0.
REQ-027 SHALL drive wr_ready all-ones and idle=1 during and after reset.
REQ-028 SHALL discard slots pending at reset assertion and never commit them.
REQ-029 SHALL NOT reset memory contents.

Configuration
REQ-030 SHALL support macro SYNC_RAM_WRITE_FORWARD_EN.
REQ-031 With SYNC_RAM_WRITE_FORWARD_EN defined: if address_r equals the address committed on the same edge, data_out SHALL take the committed data.
REQ-032 Without it: data_out SHALL return old memory contents on that collision (read-before-write).

Verification
REQ-033 Reset then idle: reset_n low 3 cycles -> wr_ready=4'b1111, idle=1, data_out=0.
REQ-034 Single write: port 2 writes addr 5 data 8'hA5 at edge N; read addr 5 -> data_out=8'hA5 at edge N+2, wr_ready[2] high again after N+1.
REQ-035 Contention: all 4 ports accepted same edge, addrs 0..3, data 8'h10..8'h13, rr_ptr=0 -> commits ports 0,1,2,3 on 4 consecutive edges, idle=1 after the 4th.
REQ-036 Round-robin fairness: ports 0 and 3 keep slots full continuously -> commits alternate 0,3,0,3; no port starves.
REQ-037 Same-address order: port 1 (8'h11) and port 2 (8'h22) to addr 7, rr_ptr=0 -> final mem[7]=8'h22; with rr_ptr=2 -> 8'h11.
REQ-038 Collision read: read addr 9 (old 8'h00) on edge committing 8'hFF to addr 9 -> data_out=8'hFF with SYNC_RAM_WRITE_FORWARD_EN, 8'h00 without; reset_n pulsed with 2 pending slots -> those addresses unchanged.

Source files
------------

// File: rtl/sync_ram_dual_multi_w_if.sv
// Bus for sync_ram_dual_multi_w: per-port posted-write handshake plus the
// single registered read port and the idle flag.
interface sync_ram_dual_multi_w_if #(
  parameter int unsigned num_in  = 4,
  parameter int unsigned d_width = 8,
  parameter int unsigned a_width = 4
);
  logic [num_in-1:0]  wr_valid;
  logic [num_in-1:0]  wr_ready;
  logic [a_width-1:0] wr_addr [num_in];
  logic [d_width-1:0] wr_data [num_in];
  logic [a_width-1:0] address_r;
  logic [d_width-1:0] data_out;
  logic               idle;

  modport master (
    output wr_valid, wr_addr, wr_data, address_r,
    input  wr_ready, data_out, idle
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, address_r,
    output wr_ready, data_out, idle
  );
endinterface

// File: rtl/sync_ram_dual_multi_w.sv
// Multi-write-port RAM: one posted-write slot per port, one round-robin commit per cycle.
// Define SYNC_RAM_WRITE_FORWARD_EN to forward same-edge committed data to the read port.
module sync_ram_dual_multi_w #(
  parameter int unsigned num_in  = 4,
  parameter int unsigned d_width = 8,
  parameter int unsigned a_width = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  sync_ram_dual_multi_w_if.slave  bus
);
  localparam int unsigned depth = 2 ** a_width;
  localparam int unsigned ptr_w = (num_in > 1) ? $clog2(num_in) : 1;

  logic [num_in-1:0]  pend_q;
  logic [a_width-1:0] addr_q [num_in];
  logic [d_width-1:0] data_q [num_in];
  logic [ptr_w-1:0]   rr_q;
  logic [d_width-1:0] mem [depth];
  logic [d_width-1:0] data_out_q;

  logic               commit_en;
  logic [ptr_w-1:0]   commit_idx;
  logic [ptr_w-1:0]   cand;
  logic [a_width-1:0] commit_addr;
  logic [d_width-1:0] commit_data;
  logic [d_width-1:0] rd_data;

  // Scan from the highest offset down so the slot nearest rr_q wins.
  always_comb begin
    commit_en  = 1'b0;
    commit_idx = '0;
    cand       = '0;
    for (int k = num_in - 1; k >= 0; k--) begin
      cand = ptr_w'((32'(rr_q) + 32'(k)) % num_in);
      if (pend_q[cand]) begin
        commit_en  = 1'b1;
        commit_idx = cand;
      end
    end
  end

  assign commit_addr = addr_q[commit_idx];
  assign commit_data = data_q[commit_idx];

  always_comb begin
    rd_data = mem[bus.address_r];
`ifdef SYNC_RAM_WRITE_FORWARD_EN
    if (commit_en && (commit_addr == bus.address_r)) begin
      rd_data = commit_data;
    end
`endif
  end

  // Accept and commit are mutually exclusive per slot: accept needs !pend, commit needs pend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      rr_q       <= '0;
      data_out_q <= '0;
    end else begin
      for (int i = 0; i < num_in; i++) begin
        if (bus.wr_valid[i] && !pend_q[i]) begin
          pend_q[i] <= 1'b1;
        end else if (commit_en && (commit_idx == ptr_w'(i))) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (commit_en) begin
        rr_q <= (commit_idx == ptr_w'(num_in - 1)) ? '0 : commit_idx + ptr_w'(1);
      end
      data_out_q <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < num_in; i++) begin
      if (bus.wr_valid[i] && !pend_q[i]) begin
        addr_q[i] <= bus.wr_addr[i];
        data_q[i] <= bus.wr_data[i];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[commit_addr] <= commit_data;
    end
  end

  assign bus.wr_ready = ~pend_q;
  assign bus.idle     = ~|pend_q;
  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_sync_ram_dual_multi_w.sv
// Directed self-checking bench for sync_ram_dual_multi_w (4 ports, 8-bit data, 16 words).
module tb_sync_ram_dual_multi_w;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  sync_ram_dual_multi_w_if #(.num_in(4), .d_width(8), .a_width(4)) bus ();

  sync_ram_dual_multi_w #(.num_in(4), .d_width(8), .a_width(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_valid  = '0;
    bus.address_r = '0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_addr[i] = '0;
      bus.wr_data[i] = '0;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.wr_ready !== 4'b1111) $display("FAIL reset_ready got %b want 1111", bus.wr_ready);
    else n_pass++;
    n_checks++;
    if (bus.idle !== 1'b1) $display("FAIL reset_idle got %b want 1", bus.idle);
    else n_pass++;
    n_checks++;
    if (bus.data_out !== 8'h00) $display("FAIL reset_data got %h want 00", bus.data_out);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (bus.wr_ready !== 4'b1111 || bus.idle !== 1'b1)
      $display("FAIL post_reset got ready=%b idle=%b want 1111/1", bus.wr_ready, bus.idle);
    else n_pass++;
  endtask

  task automatic test_single_write();
    apply_reset();
    bus.wr_valid[2] = 1'b1;
    bus.wr_addr[2]  = 4'd5;
    bus.wr_data[2]  = 8'hA5;
    tick();
    n_checks++;
    if (bus.wr_ready !== 4'b1011) $display("FAIL single_accept got %b want 1011", bus.wr_ready);
    else n_pass++;
    // Changed while pending: must be ignored.
    bus.wr_addr[2] = 4'd5;
    bus.wr_data[2] = 8'h77;
    tick();
    n_checks++;
    if (bus.wr_ready !== 4'b1111) $display("FAIL single_ready got %b want 1111", bus.wr_ready);
    else n_pass++;
    bus.wr_valid  = '0;
    bus.address_r = 4'd5;
    tick();
    n_checks++;
    if (bus.data_out !== 8'hA5) $display("FAIL single_read got %h want a5", bus.data_out);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0] exp_ready [4];
    exp_ready[0] = 4'b0001;
    exp_ready[1] = 4'b0011;
    exp_ready[2] = 4'b0111;
    exp_ready[3] = 4'b1111;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.wr_addr[i] = 4'(i);
      bus.wr_data[i] = 8'h10 + 8'(i);
    end
    bus.wr_valid = 4'b1111;
    tick();
    bus.wr_valid = '0;
    n_checks++;
    if (bus.wr_ready !== 4'b0000 || bus.idle !== 1'b0)
      $display("FAIL cont_accept got ready=%b idle=%b want 0000/0", bus.wr_ready, bus.idle);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.wr_ready !== exp_ready[i])
        $display("FAIL cont_order%0d got %b want %b", i, bus.wr_ready, exp_ready[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.idle !== 1'b1) $display("FAIL cont_idle got %b want 1", bus.idle);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.address_r = 4'(i);
      tick();
      n_checks++;
      if (bus.data_out !== 8'h10 + 8'(i))
        $display("FAIL cont_read%0d got %h want %h", i, bus.data_out, 8'h10 + 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    apply_reset();
    bus.wr_addr[0] = 4'd10;
    bus.wr_data[0] = 8'hC0;
    bus.wr_addr[3] = 4'd11;
    bus.wr_data[3] = 8'hC3;
    bus.wr_valid   = 4'b1001;
    tick();
    n_checks++;
    if (bus.wr_ready !== 4'b0110) $display("FAIL fair_e1 got %b want 0110", bus.wr_ready);
    else n_pass++;
    // Commits alternate 0,3,0,3: port 0 free after even edges, port 3 after odd ones.
    for (int e = 2; e <= 6; e++) begin
      tick();
      want = (e % 2 == 0) ? 4'b0111 : 4'b1110;
      n_checks++;
      if (bus.wr_ready !== want) $display("FAIL fair_e%0d got %b want %b", e, bus.wr_ready, want);
      else n_pass++;
    end
    bus.wr_valid = '0;
    tick();
    n_checks++;
    if (bus.idle !== 1'b1) $display("FAIL fair_drain got idle=%b want 1", bus.idle);
    else n_pass++;
  endtask

  task automatic test_same_addr();
    // rr_ptr = 0: port 1 commits first, port 2 last.
    apply_reset();
    bus.wr_addr[1] = 4'd7;
    bus.wr_data[1] = 8'h11;
    bus.wr_addr[2] = 4'd7;
    bus.wr_data[2] = 8'h22;
    bus.wr_valid   = 4'b0110;
    tick();
    bus.wr_valid = '0;
    tick();
    n_checks++;
    if (bus.wr_ready !== 4'b1011) $display("FAIL same_rr0_first got %b want 1011", bus.wr_ready);
    else n_pass++;
    tick();
    bus.address_r = 4'd7;
    tick();
    tick();
    n_checks++;
    if (bus.data_out !== 8'h22) $display("FAIL same_rr0 got %h want 22", bus.data_out);
    else n_pass++;
    // A lone port-1 commit moves rr_ptr to 2.
    apply_reset();
    bus.wr_addr[1] = 4'd12;
    bus.wr_data[1] = 8'h01;
    bus.wr_valid   = 4'b0010;
    tick();
    bus.wr_valid = '0;
    tick();
    bus.wr_addr[1] = 4'd7;
    bus.wr_data[1] = 8'h11;
    bus.wr_addr[2] = 4'd7;
    bus.wr_data[2] = 8'h22;
    bus.wr_valid   = 4'b0110;
    tick();
    bus.wr_valid = '0;
    tick();
    n_checks++;
    if (bus.wr_ready !== 4'b1101) $display("FAIL same_rr2_first got %b want 1101", bus.wr_ready);
    else n_pass++;
    tick();
    bus.address_r = 4'd7;
    tick();
    tick();
    n_checks++;
    if (bus.data_out !== 8'h11) $display("FAIL same_rr2 got %h want 11", bus.data_out);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [7:0] want;
    apply_reset();
    bus.wr_addr[0] = 4'd9;
    bus.wr_data[0] = 8'h00;
    bus.wr_valid   = 4'b0001;
    tick();
    bus.wr_valid = '0;
    tick();
    bus.wr_data[0] = 8'hFF;
    bus.wr_valid   = 4'b0001;
    tick();
    bus.wr_valid  = '0;
    bus.address_r = 4'd9;
    tick();
`ifdef SYNC_RAM_WRITE_FORWARD_EN
    want = 8'hFF;
`else
    want = 8'h00;
`endif
    n_checks++;
    if (bus.data_out !== want) $display("FAIL collide got %h want %h", bus.data_out, want);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.data_out !== 8'hFF) $display("FAIL collide_after got %h want ff", bus.data_out);
    else n_pass++;
  endtask

  task automatic test_reset_discard();
    apply_reset();
    bus.wr_addr[0] = 4'd13;
    bus.wr_data[0] = 8'h5A;
    bus.wr_addr[1] = 4'd14;
    bus.wr_data[1] = 8'h6B;
    bus.wr_valid   = 4'b0011;
    tick();
    bus.wr_valid = '0;
    repeat (3) tick();
    bus.wr_data[0] = 8'hEE;
    bus.wr_data[1] = 8'hDD;
    bus.wr_valid   = 4'b0011;
    tick();
    bus.wr_valid = '0;
    reset_n      = 1'b0;
    #1;
    n_checks++;
    if (bus.wr_ready !== 4'b1111 || bus.idle !== 1'b1)
      $display("FAIL discard_async got ready=%b idle=%b want 1111/1", bus.wr_ready, bus.idle);
    else n_pass++;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    bus.address_r = 4'd13;
    tick();
    n_checks++;
    if (bus.data_out !== 8'h5A) $display("FAIL discard_a13 got %h want 5a", bus.data_out);
    else n_pass++;
    bus.address_r = 4'd14;
    tick();
    n_checks++;
    if (bus.data_out !== 8'h6B) $display("FAIL discard_a14 got %h want 6b", bus.data_out);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_same_addr();
    test_collision();
    test_reset_discard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
